// File: rtl/test_monitor_pkg.sv
// Shared types, widths and helpers for the test_monitor result collector.
package test_monitor_pkg;

    localparam int unsigned CYCLES_W = 32;
    localparam int unsigned DRAIN_W  = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when the low 'width' bits of mask are all set.
    function automatic logic all_ones(input logic [CYCLES_W-1:0] mask, input int unsigned width);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < CYCLES_W; i++) begin
            if ((i < width) && !mask[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/test_monitor_if.sv
// Bench-side result bus: per-test fail/finish flags in, overall verdict out.
interface test_monitor_if
    import test_monitor_pkg::*;
#(
    parameter int unsigned NUM_TESTS = 4
) ();

    logic [NUM_TESTS-1:0] t_fail;
    logic [NUM_TESTS-1:0] t_finish;
    logic                 fail;
    logic                 finish;
    logic                 timeout;
    logic [NUM_TESTS-1:0] fail_mask;
    logic [CYCLES_W-1:0]  cycles;

    modport master (
        output t_fail, t_finish,
        input  fail, finish, timeout, fail_mask, cycles
    );

    modport slave (
        input  t_fail, t_finish,
        output fail, finish, timeout, fail_mask, cycles
    );

endinterface

// File: rtl/test_monitor_watchdog.sv
// Saturating run-cycle counter with a terminal-count compare against TIMEOUT-1.
module test_monitor_watchdog
    import test_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [CYCLES_W-1:0] cycles,
    output logic                expired_c
);

    localparam logic [CYCLES_W-1:0] TERMINAL   = CYCLES_W'(TIMEOUT - 1);
    localparam logic [CYCLES_W-1:0] CYCLES_MAX = '1;

    logic [CYCLES_W-1:0] next_c;

    // Expiry is judged on the value the counter takes at this edge.
    assign next_c    = (cycles == CYCLES_MAX) ? cycles : cycles + CYCLES_W'(1);
    assign expired_c = enable && (next_c == TERMINAL);

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= '0;
        end else if (enable) begin
            cycles <= next_c;
        end
    end

endmodule

// File: rtl/test_monitor.sv
// Folds per-test fail/finish flags into one sticky verdict with watchdog and drain window.
// Optional: define TEST_MONITOR_DISPLAY_EN for a simulation-only per-test report at completion.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int unsigned NUM_TESTS = 4,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned DRAIN     = 2
) (
    input  logic          clock,
    input  logic          reset,
    test_monitor_if.slave bus
);

    localparam int unsigned N = NUM_TESTS;

    state_e              state;
    logic [N-1:0]        done_mask;
    logic [N-1:0]        fail_mask;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                fail;
    logic                finish;
    logic                timeout;
    logic [CYCLES_W-1:0] cycles;

    logic [N-1:0] fail_hit_c;
    logic [N-1:0] finish_hit_c;
    logic [N-1:0] fail_mask_nx_c;
    logic [N-1:0] done_mask_nx_c;
    logic         all_done_c;
    logic         count_en_c;
    logic         expired_c;

    // Only a clean 1 counts; X/Z from a misbehaving bench is ignored.
    always_comb begin
        fail_hit_c   = '0;
        finish_hit_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            fail_hit_c[i]   = (bus.t_fail[i] === 1'b1);
            finish_hit_c[i] = (bus.t_finish[i] === 1'b1);
        end
    end

    assign fail_mask_nx_c = fail_mask | fail_hit_c;
    assign done_mask_nx_c = done_mask | finish_hit_c;
    assign all_done_c     = all_ones(CYCLES_W'(done_mask_nx_c), N);
    assign count_en_c     = (state != ST_DONE);

    test_monitor_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .enable    (count_en_c),
        .cycles    (cycles),
        .expired_c (expired_c)
    );

    // Completion is tested before expiry so a same-cycle tie goes to DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            fail      <= 1'b0;
            finish    <= 1'b0;
            timeout   <= 1'b0;
            fail_mask <= '0;
            done_mask <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    fail_mask <= fail_mask_nx_c;
                    done_mask <= done_mask_nx_c;
                    if (all_done_c) begin
                        if (DRAIN == 0) begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                            fail   <= |fail_mask_nx_c;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_W'(DRAIN);
                        end
                    end else if (expired_c) begin
                        state   <= ST_DONE;
                        finish  <= 1'b1;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    fail_mask <= fail_mask_nx_c;
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state  <= ST_DONE;
                        finish <= 1'b1;
                        fail   <= |fail_mask_nx_c;
                    end
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

    assign bus.fail      = fail;
    assign bus.finish    = finish;
    assign bus.timeout   = timeout;
    assign bus.fail_mask = fail_mask;
    assign bus.cycles    = cycles;

`ifdef TEST_MONITOR_DISPLAY_EN
    logic timeout_nx_c;
    logic to_done_c;

    assign timeout_nx_c = (state == ST_RUN) && !all_done_c && expired_c;
    assign to_done_c    = ((state == ST_RUN) && ((all_done_c && (DRAIN == 0)) || timeout_nx_c))
                       || ((state == ST_DRAIN) && (drain_cnt == DRAIN_W'(1)));

    always @(posedge clock) begin
        if (!reset && to_done_c) begin
            for (int i = 0; i < int'(N); i++) begin
                $display("[test_monitor] test %0d %s", i, fail_mask_nx_c[i] ? "FAIL" : "PASS");
            end
            $display("[test_monitor] done cycles=%0d%s",
                     (cycles == '1) ? cycles : cycles + CYCLES_W'(1),
                     timeout_nx_c ? " TIMEOUT" : "");
        end
    end
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Directed plus randomized check of test_monitor against a schedule-level verdict model.
module tb_test_monitor;

    localparam int unsigned NT      = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned DRAIN   = 2;
    localparam int          SCHED   = 64;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    test_monitor_if #(.NUM_TESTS(NT)) bus ();

    test_monitor #(
        .NUM_TESTS (NT),
        .TIMEOUT   (TIMEOUT),
        .DRAIN     (DRAIN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [NT-1:0] fin_s  [SCHED];
    logic [NT-1:0] fail_s [SCHED];

    task automatic check_outs(input string tag, input logic f, input logic fl, input logic to,
                              input logic [NT-1:0] m, input logic [31:0] cy);
        checks += 5;
        assert (bus.finish === f) else begin
            failures++;
            $error("FAIL %s.finish observed=%0b expected=%0b", tag, bus.finish, f);
        end
        assert (bus.fail === fl) else begin
            failures++;
            $error("FAIL %s.fail observed=%0b expected=%0b", tag, bus.fail, fl);
        end
        assert (bus.timeout === to) else begin
            failures++;
            $error("FAIL %s.timeout observed=%0b expected=%0b", tag, bus.timeout, to);
        end
        assert (bus.fail_mask === m) else begin
            failures++;
            $error("FAIL %s.fail_mask observed=%0b expected=%0b", tag, bus.fail_mask, m);
        end
        assert (bus.cycles === cy) else begin
            failures++;
            $error("FAIL %s.cycles observed=%0d expected=%0d", tag, bus.cycles, cy);
        end
    endtask

    task automatic clear_sched();
        for (int e = 0; e < SCHED; e++) begin
            fin_s[e]  = '0;
            fail_s[e] = '0;
        end
    endtask

    function automatic logic [NT-1:0] fails_upto(input int last);
        logic [NT-1:0] acc;
        acc = '0;
        for (int e = 1; e <= last; e++) acc |= fail_s[e];
        return acc;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset        = 1'b1;
        bus.t_fail   = '0;
        bus.t_finish = '0;
        @(posedge clock);
        #1;
        check_outs(tag, 1'b0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    // Verdict from the schedule: completion edge, drain window, watchdog at TIMEOUT-1 runs.
    task automatic run_sched(input string tag);
        logic [NT-1:0] acc;
        int            comp;
        int            d;
        logic          to;
        logic [NT-1:0] m;
        acc  = '0;
        comp = 0;
        for (int e = 1; e < SCHED; e++) begin
            acc |= fin_s[e];
            if (acc == '1 && comp == 0) comp = e;
        end
        if (comp != 0 && comp <= int'(TIMEOUT) - 1) begin
            d  = comp + int'(DRAIN);
            to = 1'b0;
        end else begin
            d  = int'(TIMEOUT) - 1;
            to = 1'b1;
        end
        m = fails_upto(d);
        for (int e = 1; e <= d + 3; e++) begin
            @(negedge clock);
            reset        = 1'b0;
            bus.t_finish = fin_s[e];
            bus.t_fail   = fail_s[e];
            @(posedge clock);
            #1;
            if (e == d - 1)
                check_outs({tag, ".pre"}, 1'b0, 1'b0, 1'b0, fails_upto(d - 1), 32'(d - 1));
            if (e == d)
                check_outs({tag, ".done"}, 1'b1, (|m) | to, to, m, 32'(d));
            if (e == d + 3)
                check_outs({tag, ".frozen"}, 1'b1, (|m) | to, to, m, 32'(d));
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.t_fail   = '0;
        bus.t_finish = '0;

        // Staggered finishes, no failures.
        do_reset("reset0");
        clear_sched();
        fin_s[3] = 4'b0001; fin_s[5] = 4'b0010; fin_s[7] = 4'b0100; fin_s[9] = 4'b1000;
        fail_s[14] = 4'b1111;
        run_sched("pass");

        // Failure reported together with its finish.
        do_reset("reset1");
        clear_sched();
        fin_s[3] = 4'b0001; fin_s[5] = 4'b0010; fin_s[7] = 4'b0100; fin_s[9] = 4'b1000;
        fail_s[7] = 4'b0100;
        run_sched("fail2");

        // Late failure inside drain counts, after DONE is ignored.
        do_reset("reset2");
        clear_sched();
        fin_s[4] = 4'b1111;
        fail_s[5] = 4'b0001; fail_s[8] = 4'b0010;
        run_sched("drainfail");

        // Test 3 never finishes; orphan fail pulse still recorded.
        do_reset("reset3");
        clear_sched();
        fin_s[2] = 4'b0111;
        fail_s[5] = 4'b1000;
        run_sched("watchdog");

        // Completion on the expiry cycle wins over the watchdog.
        do_reset("reset4");
        clear_sched();
        fin_s[2] = 4'b0111; fin_s[19] = 4'b1000;
        run_sched("tie");

        // Reset while in DRAIN clears everything, then a clean pass run.
        do_reset("reset5");
        clear_sched();
        fin_s[4] = 4'b1111; fail_s[3] = 4'b0010;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clock);
            reset        = 1'b0;
            bus.t_finish = fin_s[e];
            bus.t_fail   = fail_s[e];
            @(posedge clock);
        end
        do_reset("reset_in_drain");
        clear_sched();
        fin_s[3] = 4'b0001; fin_s[5] = 4'b0010; fin_s[7] = 4'b0100; fin_s[9] = 4'b1000;
        run_sched("after_reset");

        // Randomized schedules, some of which overrun the watchdog.
        for (int r = 0; r < 24; r++) begin
            do_reset("reset_rnd");
            clear_sched();
            for (int b = 0; b < int'(NT); b++) begin
                if ($urandom_range(0, 9) != 0) fin_s[$urandom_range(1, 22)][b] = 1'b1;
                for (int e = 1; e < 30; e++) begin
                    if ($urandom_range(0, 15) == 0) fail_s[e][b] = 1'b1;
                end
            end
            run_sched($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
